// File: rtl/serial_cmp_pkg.sv
// rtl/serial_cmp_pkg.sv - shared types and defaults for the bit-serial magnitude comparator
package serial_cmp_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } result_t;

  localparam result_t RESULT_NONE = '0;

endpackage

// File: rtl/serial_cmp_idx_cnt.sv
// rtl/serial_cmp_idx_cnt.sv - loadable bit-index down-counter that saturates at zero
module serial_cmp_idx_cnt #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             dec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             is_zero_o
);

  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (load_i) begin
      idx_d = IDX_W'(WIDTH - 1);
    end else if (dec_i && (idx_q != '0)) begin
      idx_d = idx_q - IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o     = idx_q;
  assign is_zero_o = (idx_q == '0);

endmodule

// File: rtl/serial_cmp_ctrl.sv
// rtl/serial_cmp_ctrl.sv - MSB-first magnitude compare through one shared 1-bit equality cell
// Optional SERIAL_CMP_EARLY_EXIT_EN: leave RUN on the first mismatching bit.
module serial_cmp_ctrl
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             cmp_x,
  output logic             cmp_y,
  input  logic             cmp_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic             busy
);

  localparam int IDX_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  result_t          res_q, res_d;
  logic             mm_q, mm_d;
  logic             idx_load, idx_dec, idx_zero, hit, accept;
  logic [IDX_W-1:0] idx;

  serial_cmp_idx_cnt #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_idx_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (idx_load),
    .dec_i     (idx_dec),
    .idx_o     (idx),
    .is_zero_o (idx_zero)
  );

  assign accept = (state_q == S_IDLE) && in_valid;

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    mm_d     = mm_q;
    idx_load = 1'b0;
    idx_dec  = 1'b0;
    cmp_x    = 1'b0;
    cmp_y    = 1'b0;
    hit      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          idx_load = 1'b1;
          mm_d     = 1'b0;
          res_d    = RESULT_NONE;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        cmp_x = a_q[idx];
        cmp_y = b_q[idx];
        hit   = !cmp_z && !mm_q;
        // Only the most significant mismatch decides the ordering.
        if (hit) begin
          res_d = '{eq: 1'b0, gt: cmp_x, lt: ~cmp_x};
          mm_d  = 1'b1;
        end else if (idx_zero && !mm_q) begin
          res_d = '{eq: 1'b1, gt: 1'b0, lt: 1'b0};
        end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        if (idx_zero || hit) begin
          state_d = S_DONE;
        end else begin
          idx_dec = 1'b1;
        end
`else
        if (idx_zero) begin
          state_d = S_DONE;
        end else begin
          idx_dec = 1'b1;
        end
`endif
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      res_q   <= RESULT_NONE;
      mm_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      mm_q    <= mm_d;
      if (accept) begin
        a_q <= a;
        b_q <= b;
      end
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign out_valid    = (state_q == S_DONE);
  assign {eq, gt, lt} = out_valid ? res_q : RESULT_NONE;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// tb/tb_serial_cmp_ctrl.sv - self-checking bench for serial_cmp_ctrl (either SERIAL_CMP_EARLY_EXIT_EN build)
module tb_serial_cmp_ctrl;

  localparam int W = 8;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, cmp_x, cmp_y, cmp_z, out_valid, eq, gt, lt, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign cmp_z = (cmp_x == cmp_y);

  serial_cmp_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cmp_x     (cmp_x),
    .cmp_y     (cmp_y),
    .cmp_z     (cmp_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .eq        (eq),
    .gt        (gt),
    .lt        (lt),
    .busy      (busy)
  );

  // Transaction model: cycles elapsed since accept, against a latency derived from the operands.
  logic         m_busy = 1'b0;
  int           m_k = 0;
  int           m_lat = W;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;

  function automatic int lat_of(input logic [W-1:0] x, input logic [W-1:0] y);
    for (int i = W - 1; i >= 0; i--) begin
      if (x[i] != y[i]) return EE ? (W - i) : W;
    end
    return W;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_k    <= 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_k    <= 0;
        m_a    <= a;
        m_b    <= b;
        m_lat  <= lat_of(a, b);
      end
    end else if (m_k < m_lat) begin
      m_k <= m_k + 1;
    end else if (out_ready) begin
      m_busy <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input int hold,
                      input bit chg, output int lat, output logic [W-1:0] xs,
                      output logic [W-1:0] ys, output logic [2:0] fl);
    @(posedge clk); #2;
    a = ta; b = tb_v; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    if (chg) begin a = 8'hFF; b = 8'h00; end
    lat = -1; xs = '0; ys = '0; fl = '0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n - 1;
        fl  = {eq, gt, lt};
        break;
      end
      xs = {xs[W-2:0], cmp_x};
      ys = {ys[W-2:0], cmp_y};
    end
    if (lat < 0) chk("timeout_out_valid", 32'(out_valid), 32'd1);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #2;
      in_valid = 1'b1; a = 8'h00; b = 8'hFF;
    end
    if (hold > 0) begin
      chk("hold_vflags", 32'({out_valid, eq, gt, lt}), 32'b1010);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #2;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_flags", 32'({eq, gt, lt}), 32'd0);
    chk("rst_cmp", 32'({cmp_x, cmp_y}), 32'd0);
  endtask

  initial begin
    int           lat;
    logic [W-1:0] xs, ys;
    logic [2:0]   fl;

    fork
      forever begin
        logic run, dn;
        @(negedge clk);
        run = m_busy && (m_k < m_lat);
        dn  = m_busy && (m_k == m_lat);
        chk("in_ready", 32'(in_ready), 32'(!m_busy));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("out_valid", 32'(out_valid), 32'(dn));
        chk("cmp_x", 32'(cmp_x), run ? 32'(m_a[W-1-m_k]) : 32'd0);
        chk("cmp_y", 32'(cmp_y), run ? 32'(m_b[W-1-m_k]) : 32'd0);
        chk("flags", 32'({eq, gt, lt}),
            dn ? 32'({m_a == m_b, m_a > m_b, m_a < m_b}) : 32'd0);
      end
    join_none

    #1;
    chk_reset_vals();
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;

    send(8'hA5, 8'hA5, 0, 1'b0, lat, xs, ys, fl);
    chk("a5_lat", 32'(lat), 32'd8);
    chk("a5_xseq", 32'(xs), 32'hA5);
    chk("a5_yseq", 32'(ys), 32'hA5);
    chk("a5_flags", 32'(fl), 32'b100);

    send(8'h80, 8'h7F, 0, 1'b0, lat, xs, ys, fl);
    chk("80_lat", 32'(lat), EE ? 32'd1 : 32'd8);
    chk("80_flags", 32'(fl), 32'b010);

    send(8'h12, 8'h13, 0, 1'b0, lat, xs, ys, fl);
    chk("12_lat", 32'(lat), 32'd8);
    chk("12_flags", 32'(fl), 32'b001);

    send(8'h40, 8'h00, 5, 1'b0, lat, xs, ys, fl);
    chk("40_lat", 32'(lat), EE ? 32'd2 : 32'd8);
    chk("40_flags", 32'(fl), 32'b010);

    send(8'h3C, 8'h3C, 0, 1'b1, lat, xs, ys, fl);
    chk("3c_lat", 32'(lat), 32'd8);
    chk("3c_flags", 32'(fl), 32'b100);

    @(posedge clk); #2;
    a = 8'h0F; b = 8'hF0; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    chk("abort_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;

    send(8'h01, 8'h02, 0, 1'b0, lat, xs, ys, fl);
    chk("01_lat", 32'(lat), EE ? 32'd7 : 32'd8);
    chk("01_flags", 32'(fl), 32'b001);

    @(posedge clk); @(posedge clk); #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
